bf_program_loader: RTL and testbench
====================================

Name: bf_program_loader

Overview:
- Fills the Brainfuck core's program memory from an ASCII character stream, encoding each Brainfuck source character into the core's 8-bit instruction word.
- It is the writer/encoder for the program memory that the core reads and decodes.
- Sits between a byte source (UART receiver or testbench) and the program-memory write port. The core is held off, externally, until o_done is high.

Parameters:
- ADDR_W, 8, program-memory address width; capacity is 2**ADDR_W words.
- STACK_W, 4, core stack address width; the maximum legal bracket nesting depth is 2**STACK_W - 1.

Ports:
- i_clock  input  1  system clock; all state updates on the rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- i_valid  input  1  i_char is valid.
- i_char  input  8  ASCII character.
- o_ready  output  1  loader accepts i_char this cycle.
- o_prgmem_we  output  1  program-memory write strobe, one cycle per word.
- o_prgmem_addr  output  ADDR_W  write address.
- o_prgmem_data  output  8  encoded instruction word.
- o_busy  output  1  high in LOAD and TERM.
- o_done  output  1  load finished cleanly; held until the next i_start.
- o_error  output  1  load aborted; held until the next i_start.
- o_length  output  ADDR_W  number of instruction words written, excluding the terminator.

Behaviour:
- Reset values: every output is 0; state is IDLE; the internal address counter and depth counter are 0.
- Instruction encoding (bits [7:5] are always 0; bit order is {tape_wr, ptr_wr, push, pop, dec}):
  - '+' (0x2B) -> 0x10
  - '-' (0x2D) -> 0x11
  - '>' (0x3E) -> 0x08
  - '<' (0x3C) -> 0x09
  - '[' (0x5B) -> 0x04
  - ']' (0x5D) -> 0x03
- Character classes:
  - End characters are 0x00 and '!' (0x21).
  - Every other character is a comment: it is accepted and discarded, with no write and no counter change.
- Handshake:
  - A character transfers when i_valid && o_ready.
  - o_ready is a registered output and is high only in LOAD.
  - i_char must be held stable while i_valid is high and o_ready is low.
- Write timing:
  - The write is registered. In the cycle after an instruction character is accepted: we=1, addr=counter, data=encoding.
  - The counter increments on that same accept edge.
  - Throughput is one character per cycle.
- State transitions:
  - IDLE --i_start--> LOAD. On entry: counter=0, depth=0, and o_done and o_error are cleared.
  - LOAD --instruction character--> LOAD, issuing a write.
  - LOAD --end character--> TERM. o_ready drops on the next edge.
  - TERM: writes 0x00 (NOP) at the counter value for one cycle and sets o_length=counter, then goes to DONE (or to ERROR on an end-of-load depth failure).
  - DONE and ERROR: o_ready=0, and the state persists. i_start re-enters LOAD.
- Capacity limit: address 2**ADDR_W-1 is reserved for the terminator. An instruction character accepted when counter==2**ADDR_W-1 produces no write and the loader goes to ERROR.
- i_start while o_busy is high is ignored.
- i_reset asserted mid-load forces IDLE immediately, including the write strobe. Words already written are not cleared.
- The counter never wraps.

Optional Feature:
- Macro: BF_LOADER_BRACKET_CHECK_EN.
- When defined:
  - The loader tracks depth: '[' adds 1 and ']' subtracts 1, updated on accept.
  - '[' at depth 2**STACK_W-1 goes to ERROR with no write.
  - ']' at depth 0 goes to ERROR with no write.
  - An end character accepted at depth != 0 still writes the terminator in TERM, then goes to ERROR instead of DONE.
- When undefined: no depth counter, and brackets are never an error source. Only capacity overflow produces ERROR.

Decomposition:
- Shared package bf_pkg holds:
  - the opcode constants OP_INC, OP_DEC, OP_RIGHT, OP_LEFT, OP_OPEN, OP_CLOSE, OP_NOP;
  - the character constants for the six instructions and the two end characters;
  - the state encoding.
- The core and this loader both use these opcode constants.
- One combinational sub-module, bf_char_encoder: input i_char; outputs o_is_instr, o_is_end, o_word.

Test Plan:
- Stream "+-><[]!" after i_start. Required: writes 0x10,0x11,0x08,0x09,0x04,0x03 at addresses 0-5, then 0x00 at 6; o_length=6; o_done=1; o_error=0.
- Stream "a+ b\n-" then 0x00, with i_valid toggling randomly. Required: only 0x10@0 and 0x11@1, then 0x00@2; o_length=2; no write for a comment character.
- With the macro defined, stream "[[-]" then "!". Required: 0x00 terminator at address 4, then o_error=1 and o_done=0. Stream "]" alone. Required: ERROR with no write.
- With the macro defined, stream 16 '[' characters with STACK_W=4. Required: 15 writes, and the 16th goes to ERROR without a write.
- With ADDR_W=3, stream 8 '+' characters. Required: writes at addresses 0-6, the 8th character goes to ERROR, and no terminator is written.
- Assert i_reset during the write cycle of the third character. Required: all outputs are 0 in the same cycle. A following i_start reloads from address 0.

Source files
------------

// File: rtl/bf_program_loader_pkg.sv
// +------------------------------------------------------------------+
// | Package : bf_pkg                                                 |
// | Opcodes, source characters and loader state encoding shared by   |
// | the Brainfuck core and its program loader.                       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package bf_pkg;

  // Instruction word bits [4:0] = {tape_wr, ptr_wr, push, pop, dec}
  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_INC   = 8'h10;
  localparam logic [7:0] OP_DEC   = 8'h11;
  localparam logic [7:0] OP_RIGHT = 8'h08;
  localparam logic [7:0] OP_LEFT  = 8'h09;
  localparam logic [7:0] OP_OPEN  = 8'h04;
  localparam logic [7:0] OP_CLOSE = 8'h03;

  localparam logic [7:0] CH_INC      = 8'h2B;
  localparam logic [7:0] CH_DEC      = 8'h2D;
  localparam logic [7:0] CH_RIGHT    = 8'h3E;
  localparam logic [7:0] CH_LEFT     = 8'h3C;
  localparam logic [7:0] CH_OPEN     = 8'h5B;
  localparam logic [7:0] CH_CLOSE    = 8'h5D;
  localparam logic [7:0] CH_END_NUL  = 8'h00;
  localparam logic [7:0] CH_END_BANG = 8'h21;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_TERM  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/bf_program_loader_if.sv
// +------------------------------------------------------------------+
// | Interface : bf_program_loader_if                                 |
// | Character stream handshake plus program-memory write port.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

interface bf_program_loader_if #(
  parameter int ADDR_W = 8
);
  logic              i_valid;
  logic [7:0]        i_char;
  logic              o_ready;
  logic              o_prgmem_we;
  logic [ADDR_W-1:0] o_prgmem_addr;
  logic [7:0]        o_prgmem_data;

  modport master (
    output i_valid, i_char,
    input  o_ready, o_prgmem_we, o_prgmem_addr, o_prgmem_data
  );

  modport slave (
    input  i_valid, i_char,
    output o_ready, o_prgmem_we, o_prgmem_addr, o_prgmem_data
  );
endinterface

`default_nettype wire

// File: rtl/bf_program_loader_encoder.sv
// +------------------------------------------------------------------+
// | Module : bf_char_encoder                                         |
// | Classifies one ASCII character and maps it to an instruction.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module bf_char_encoder
  import bf_pkg::*;
(
  input  logic [7:0] i_char,
  output logic       o_is_instr,
  output logic       o_is_end,
  output logic [7:0] o_word
);

  always_comb begin
    o_is_instr = 1'b1;
    o_is_end   = 1'b0;
    o_word     = OP_NOP;
    case (i_char)
      CH_INC:   o_word = OP_INC;
      CH_DEC:   o_word = OP_DEC;
      CH_RIGHT: o_word = OP_RIGHT;
      CH_LEFT:  o_word = OP_LEFT;
      CH_OPEN:  o_word = OP_OPEN;
      CH_CLOSE: o_word = OP_CLOSE;
      CH_END_NUL, CH_END_BANG: begin
        o_is_instr = 1'b0;
        o_is_end   = 1'b1;
      end
      default:  o_is_instr = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/bf_program_loader.sv
// +------------------------------------------------------------------+
// | Module : bf_program_loader                                       |
// | Encodes a Brainfuck character stream into program memory.        |
// | Option : BF_LOADER_BRACKET_CHECK_EN enables bracket depth check. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module bf_program_loader
  import bf_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int STACK_W = 4
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  bf_program_loader_if.slave  bus,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error,
  output logic [ADDR_W-1:0]   o_length
);

  localparam logic [ADDR_W-1:0] CNT_MAX = '1;

  generate
    if (ADDR_W < 2 || STACK_W < 1) begin : g_param_check
      $error("bf_program_loader: ADDR_W must be >= 2 and STACK_W >= 1");
    end
  endgenerate

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] length_q, length_d;
  logic [7:0]        data_q, data_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              w_is_instr, w_is_end, w_acc;
  logic [7:0]        w_word;
  logic              w_bracket_err, w_depth_bad;

  bf_char_encoder u_enc (
    .i_char     (bus.i_char),
    .o_is_instr (w_is_instr),
    .o_is_end   (w_is_end),
    .o_word     (w_word)
  );

`ifdef BF_LOADER_BRACKET_CHECK_EN
  localparam logic [STACK_W-1:0] DEPTH_MAX = '1;
  logic [STACK_W-1:0] depth_q, depth_d;

  assign w_bracket_err = ((w_word == OP_OPEN)  && (depth_q == DEPTH_MAX)) ||
                         ((w_word == OP_CLOSE) && (depth_q == '0));
  assign w_depth_bad   = (depth_q != '0);
`else
  assign w_bracket_err = 1'b0;
  assign w_depth_bad   = 1'b0;
`endif

  assign w_acc = bus.i_valid && ready_q;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      length_q <= '0;
      data_q   <= '0;
      ready_q  <= 1'b0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
`ifdef BF_LOADER_BRACKET_CHECK_EN
      depth_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      length_q <= length_d;
      data_q   <= data_d;
      ready_q  <= ready_d;
      we_q     <= we_d;
      done_q   <= done_d;
      error_q  <= error_d;
`ifdef BF_LOADER_BRACKET_CHECK_EN
      depth_q  <= depth_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    length_d = length_q;
    data_d   = data_q;
    ready_d  = ready_q;
    we_d     = 1'b0;
    done_d   = done_q;
    error_d  = error_q;
`ifdef BF_LOADER_BRACKET_CHECK_EN
    depth_d  = depth_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (i_start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
          ready_d = 1'b1;
`ifdef BF_LOADER_BRACKET_CHECK_EN
          depth_d = '0;
`endif
        end
      end
      ST_LOAD: begin
        if (w_acc && w_is_end) begin
          state_d = ST_TERM;
          ready_d = 1'b0;
          we_d    = 1'b1;
          addr_d  = cnt_q;
          data_d  = OP_NOP;
        end else if (w_acc && w_is_instr) begin
          // The last address is kept free for the terminator word.
          if ((cnt_q == CNT_MAX) || w_bracket_err) begin
            state_d = ST_ERROR;
            ready_d = 1'b0;
            error_d = 1'b1;
          end else begin
            we_d   = 1'b1;
            addr_d = cnt_q;
            data_d = w_word;
            cnt_d  = cnt_q + 1'b1;
`ifdef BF_LOADER_BRACKET_CHECK_EN
            if (w_word == OP_OPEN)  depth_d = depth_q + 1'b1;
            if (w_word == OP_CLOSE) depth_d = depth_q - 1'b1;
`endif
          end
        end
      end
      ST_TERM: begin
        length_d = cnt_q;
        if (w_depth_bad) begin
          state_d = ST_ERROR;
          error_d = 1'b1;
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.o_ready       = ready_q;
  assign bus.o_prgmem_we   = we_q;
  assign bus.o_prgmem_addr = addr_q;
  assign bus.o_prgmem_data = data_q;
  assign o_busy            = (state_q == ST_LOAD) || (state_q == ST_TERM);
  assign o_done            = done_q;
  assign o_error           = error_q;
  assign o_length          = length_q;

endmodule

`default_nettype wire

// File: tb/tb_bf_program_loader.sv
// +------------------------------------------------------------------+
// | Module : tb_bf_program_loader                                    |
// | Scoreboard bench: a wide loader and a 3-bit-address loader.      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tb_bf_program_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start8 = 1'b0;
  logic start3 = 1'b0;
  logic busy8, done8, error8, busy3, done3, error3;
  logic [7:0] len8;
  logic [2:0] len3;

  int  n_vec = 0;
  int  n_err = 0;
  bit  gap_en = 1'b0;
  logic [15:0] exp8[$];
  logic [15:0] exp3[$];

  always #5 clk = ~clk;

  bf_program_loader_if #(.ADDR_W(8)) bus8 ();
  bf_program_loader_if #(.ADDR_W(3)) bus3 ();

  bf_program_loader #(.ADDR_W(8), .STACK_W(4)) dut (
    .i_clock (clk), .i_reset (rst), .i_start (start8), .bus (bus8.slave),
    .o_busy (busy8), .o_done (done8), .o_error (error8), .o_length (len8)
  );

  bf_program_loader #(.ADDR_W(3), .STACK_W(4)) dut_s (
    .i_clock (clk), .i_reset (rst), .i_start (start3), .bus (bus3.slave),
    .o_busy (busy3), .o_done (done3), .o_error (error3), .o_length (len3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitors: every strobe must match the oldest expected {addr,data}.
  always @(negedge clk) begin
    if (bus8.o_prgmem_we === 1'b1) begin
      if (exp8.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL wr8_unexpected: got addr 0x%0h data 0x%0h, expected no write",
                 bus8.o_prgmem_addr, bus8.o_prgmem_data);
      end else begin
        chk("wr8", {16'h0, bus8.o_prgmem_addr, bus8.o_prgmem_data}, {16'h0, exp8.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (bus3.o_prgmem_we === 1'b1) begin
      if (exp3.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL wr3_unexpected: got addr 0x%0h data 0x%0h, expected no write",
                 bus3.o_prgmem_addr, bus3.o_prgmem_data);
      end else begin
        chk("wr3", {16'h0, 5'h0, bus3.o_prgmem_addr, bus3.o_prgmem_data}, {16'h0, exp3.pop_front()});
      end
    end
  end

  task automatic pw(input int which, input logic [7:0] a, input logic [7:0] d);
    if (which == 0) exp8.push_back({a, d});
    else            exp3.push_back({a, d});
  endtask

  task automatic pulse_start(input int which);
    if (which == 0) start8 = 1'b1; else start3 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic put(input int which, input logic [7:0] c);
    int  g;
    logic ok;
    if (gap_en) begin
      bus8.i_valid = 1'b0;
      bus3.i_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    g = 0;
    if (which == 0) begin
      bus8.i_valid = 1'b1; bus8.i_char = c;
      while (!bus8.o_ready && g < 20) begin @(negedge clk); g++; end
      ok = bus8.o_ready;
    end else begin
      bus3.i_valid = 1'b1; bus3.i_char = c;
      while (!bus3.o_ready && g < 20) begin @(negedge clk); g++; end
      ok = bus3.o_ready;
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL put_timeout: ready 0, expected 1 within 20 cycles");
    end
    @(negedge clk);
    bus8.i_valid = 1'b0;
    bus3.i_valid = 1'b0;
  endtask

  task automatic send(input int which, input string s);
    for (int i = 0; i < s.len(); i++) put(which, s[i]);
  endtask

  task automatic wait_fin(input int which);
    int g = 0;
    if (which == 0) while (!(done8 || error8) && g < 10) begin @(negedge clk); g++; end
    else            while (!(done3 || error3) && g < 10) begin @(negedge clk); g++; end
    if (g >= 10) begin
      n_vec++; n_err++;
      $display("FAIL fin_timeout: done/error 0, expected one set within 10 cycles");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_end8(input string name, input logic d, input logic e, input logic [7:0] l);
    chk({name, "_done"},  done8,  d);
    chk({name, "_error"}, error8, e);
    chk({name, "_len"},   len8,   l);
    chk({name, "_busy"},  busy8,  1'b0);
    chk({name, "_drain"}, exp8.size(), 0);
  endtask

  initial begin
    bus8.i_valid = 1'b0; bus8.i_char = 8'h0;
    bus3.i_valid = 1'b0; bus3.i_char = 8'h0;
    repeat (3) @(negedge clk);
    chk("rst_outs8", {ready_we8(), busy8, done8, error8, len8, bus8.o_prgmem_addr, bus8.o_prgmem_data}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs3", {bus3.o_ready, bus3.o_prgmem_we, busy3, done3, error3, len3}, 0);

    // All six instructions then '!'
    pulse_start(0);
    chk("load_ready", {bus8.o_ready, busy8}, 2'b11);
    pw(0, 0, 8'h10); pw(0, 1, 8'h11); pw(0, 2, 8'h08);
    pw(0, 3, 8'h09); pw(0, 4, 8'h04); pw(0, 5, 8'h03); pw(0, 6, 8'h00);
    send(0, "+-><[]!");
    wait_fin(0);
    chk_end8("all6", 1'b1, 1'b0, 8'd6);
    chk("all6_ready", bus8.o_ready, 1'b0);

    // Comments ignored, NUL terminator, gappy valid
    gap_en = 1'b1;
    pulse_start(0);
    chk("restart_clr", {done8, error8}, 2'b00);
    pw(0, 0, 8'h10); pw(0, 1, 8'h11); pw(0, 2, 8'h00);
    send(0, "a+ b\n-");
    put(0, 8'h00);
    wait_fin(0);
    gap_en = 1'b0;
    chk_end8("cmt", 1'b1, 1'b0, 8'd2);

    // i_start during LOAD must not restart the counter
    pulse_start(0);
    pw(0, 0, 8'h10); pw(0, 1, 8'h09); pw(0, 2, 8'h00);
    put(0, "+");
    pulse_start(0);
    send(0, "<!");
    wait_fin(0);
    chk_end8("busy_start", 1'b1, 1'b0, 8'd2);

    // Capacity: 7 instructions fill 0..6, terminator lands at 7
    pulse_start(1);
    for (int i = 0; i < 7; i++) pw(1, i[7:0], 8'h10);
    pw(1, 7, 8'h00);
    send(1, "+++++++!");
    wait_fin(1);
    chk("cap7", {done3, error3, len3, exp3.size() == 0}, {1'b1, 1'b0, 3'd7, 1'b1});

    // Capacity overflow: 8th instruction errors with no terminator
    pulse_start(1);
    for (int i = 0; i < 7; i++) pw(1, i[7:0], 8'h10);
    send(1, "++++++++");
    wait_fin(1);
    chk("cap8", {done3, error3, busy3, bus3.o_ready, exp3.size() == 0}, {1'b0, 1'b1, 1'b0, 1'b0, 1'b1});

`ifdef BF_LOADER_BRACKET_CHECK_EN
    pulse_start(0);
    pw(0, 0, 8'h04); pw(0, 1, 8'h04); pw(0, 2, 8'h11); pw(0, 3, 8'h03); pw(0, 4, 8'h00);
    send(0, "[[-]!");
    wait_fin(0);
    chk_end8("unbal", 1'b0, 1'b1, 8'd4);

    pulse_start(0);
    send(0, "]");
    wait_fin(0);
    chk("close0", {done8, error8, exp8.size() == 0}, 3'b011);

    pulse_start(0);
    for (int i = 0; i < 15; i++) pw(0, i[7:0], 8'h04);
    for (int i = 0; i < 16; i++) put(0, "[");
    wait_fin(0);
    chk("deep16", {done8, error8, exp8.size() == 0}, 3'b011);
`else
    pulse_start(0);
    pw(0, 0, 8'h03); pw(0, 1, 8'h04); pw(0, 2, 8'h00);
    send(0, "][!");
    wait_fin(0);
    chk_end8("nobrk", 1'b1, 1'b0, 8'd2);
`endif

    // Reset during the write cycle of the third character
    pulse_start(0);
    pw(0, 0, 8'h10); pw(0, 1, 8'h11);
    put(0, "+");
    put(0, "-");
    bus8.i_valid = 1'b1; bus8.i_char = ">";
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("rst_mid", {ready_we8(), busy8, done8, error8, len8, bus8.o_prgmem_addr, bus8.o_prgmem_data}, 0);
    bus8.i_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_start(0);
    pw(0, 0, 8'h09); pw(0, 1, 8'h00);
    send(0, "<!");
    wait_fin(0);
    chk_end8("reload", 1'b1, 1'b0, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  function automatic logic [1:0] ready_we8();
    return {bus8.o_ready, bus8.o_prgmem_we};
  endfunction

endmodule

`default_nettype wire
